hyperram_auto_test: RTL and testbench

- Autonomous HyperRAM loopback tester that sits directly downstream of the register block.
- Consumes the register block's auto-test controls (manual/auto select, LFSR mode, clear-fail, start/stop address, wait value).
- Drives a single-outstanding-command port into the HyperRAM bus master controller and returns pass/fail, iteration, error and address status for register readback.
- Each iteration writes a data pattern across an address window, then reads it back and compares.

---
 rtl/hyperram_auto_test.sv | 257 +++++++++++++++++++++++++
 tb/tb_hyperram_auto_test.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_auto_test.sv
// -----------------------------------------------------------------------------
// hyperram_auto_test
//
// Autonomous HyperRAM loopback tester. Each iteration writes a data pattern
// (word address or a 32-bit Galois LFSR sequence) across an inclusive address
// window, then reads the window back and compares. It drives a
// single-outstanding command port into the HyperRAM bus master and reports
// pass/fail, iteration, error and address status for register readback.
//
// Ports
//   hclk                 HyperRAM-domain clock (only clock)
//   reset_i              asynchronous, active-high reset
//   I_lb_manual          1 = idle, 0 = run continuously (usb domain, synchronised)
//   I_clear_fail         level clear of fail/errors/error_addr (usb domain, synchronised)
//   I_lfsr_mode          1 = LFSR data, 0 = data equals address (sampled per iteration)
//   I_start_addr/I_stop_addr  inclusive word window (sampled per iteration)
//   I_wait_value         idle cycles inserted after each completed command
//   O_cmd_*/I_cmd_ready  command request channel (valid/ready)
//   I_rd_valid/I_rd_data read return strobe and data
//   O_auto_*             status for register readback
//   O_busy               high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module hyperram_auto_test #(
  parameter logic [31:0] pLFSR_SEED = 32'hACE1_0001,
  parameter logic [31:0] pLFSR_TAPS = 32'h8020_0003
) (
  input  logic        hclk,
  input  logic        reset_i,
  input  logic        I_lb_manual,
  input  logic        I_clear_fail,
  input  logic        I_lfsr_mode,
  input  logic [31:0] I_start_addr,
  input  logic [31:0] I_stop_addr,
  input  logic [7:0]  I_wait_value,
  output logic        O_cmd_valid,
  input  logic        I_cmd_ready,
  output logic        O_cmd_write,
  output logic [31:0] O_cmd_addr,
  output logic [31:0] O_cmd_wdata,
  input  logic        I_rd_valid,
  input  logic [31:0] I_rd_data,
  output logic        O_auto_pass,
  output logic        O_auto_fail,
  output logic [15:0] O_auto_iterations,
  output logic [31:0] O_auto_current_addr,
  output logic [31:0] O_auto_errors,
  output logic [31:0] O_auto_error_addr,
  output logic        O_busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_REQ    = 3'd1;
  localparam logic [2:0] ST_WR_GAP    = 3'd2;
  localparam logic [2:0] ST_RD_REQ    = 3'd3;
  localparam logic [2:0] ST_RD_WAIT   = 3'd4;
  localparam logic [2:0] ST_RD_GAP    = 3'd5;
  localparam logic [2:0] ST_ITER_DONE = 3'd6;

  // Right-shifting Galois step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ pLFSR_TAPS) : (v >> 1);
  endfunction

  // Control synchronisers
  logic lb_manual_meta, lb_manual_s;
  logic clear_fail_meta, clear_fail_s;

  // State and next-state
  logic [2:0]  state, state_n;
  logic [31:0] addr, addr_n;
  logic [31:0] start_q, start_n;
  logic [31:0] stop_q, stop_n;
  logic        mode_q, mode_n;
  logic [31:0] lfsr, lfsr_n;
  logic [7:0]  gap_cnt, gap_cnt_n;
  logic        iter_seen, iter_seen_n;
  logic        pass_n, fail_n;
  logic [15:0] iterations_n;
  logic [31:0] current_addr_n, errors_n, error_addr_n;

  // Decode helpers
  logic [31:0] pattern;
  logic        handshake, last_word, write_phase;
  logic        cmd_done, step, start_iter;

  assign pattern     = mode_q ? lfsr : addr;
  assign O_cmd_valid = (state == ST_WR_REQ) || (state == ST_RD_REQ);
  assign O_cmd_write = (state == ST_WR_REQ);
  assign O_cmd_addr  = addr;
  assign O_cmd_wdata = pattern;
  assign O_busy      = (state != ST_IDLE);
  assign handshake   = O_cmd_valid && I_cmd_ready;
  // An inverted window collapses to the single word start_addr.
  assign last_word   = (addr == stop_q) || (stop_q < start_q);
  assign write_phase = (state == ST_WR_REQ) || (state == ST_WR_GAP);

  // Manual select resets high so the tester stays idle until told to run.
  always_ff @(posedge hclk or posedge reset_i) begin
    if (reset_i) begin
      lb_manual_meta  <= 1'b1;
      lb_manual_s     <= 1'b1;
      clear_fail_meta <= 1'b0;
      clear_fail_s    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop samples
      // pre-edge values; blocking here would collapse the two sync stages.
      lb_manual_meta  <= I_lb_manual;
      lb_manual_s     <= lb_manual_meta;
      clear_fail_meta <= I_clear_fail;
      clear_fail_s    <= clear_fail_meta;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default here, otherwise paths that do not
    // assign it would infer a latch.
    state_n        = state;
    addr_n         = addr;
    start_n        = start_q;
    stop_n         = stop_q;
    mode_n         = mode_q;
    lfsr_n         = lfsr;
    gap_cnt_n      = gap_cnt;
    iter_seen_n    = iter_seen;
    fail_n         = O_auto_fail;
    iterations_n   = O_auto_iterations;
    current_addr_n = O_auto_current_addr;
    errors_n       = O_auto_errors;
    error_addr_n   = O_auto_error_addr;
    cmd_done       = 1'b0;
    step           = 1'b0;
    start_iter     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!lb_manual_s) start_iter = 1'b1;
      end
      ST_WR_REQ: begin
        if (handshake) begin
          current_addr_n = addr;
          lfsr_n         = lfsr_next(lfsr);
          cmd_done       = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (handshake) begin
          current_addr_n = addr;
          state_n        = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (I_rd_valid) begin
          lfsr_n   = lfsr_next(lfsr);
          cmd_done = 1'b1;
          if (I_rd_data != pattern) begin
            if (O_auto_errors != 32'hFFFF_FFFF) errors_n = O_auto_errors + 32'd1;
            fail_n = 1'b1;
            if (O_auto_errors == 32'd0) error_addr_n = addr;
          end
        end
      end
      ST_WR_GAP, ST_RD_GAP: begin
        // No transfer is in flight during a gap, so a stop request exits now.
        if (lb_manual_s)              state_n   = ST_IDLE;
        else if (gap_cnt == 8'd1)     step      = 1'b1;
        else                          gap_cnt_n = gap_cnt - 8'd1;
      end
      ST_ITER_DONE: begin
        iterations_n = O_auto_iterations + 16'd1;
        iter_seen_n  = 1'b1;
        if (!lb_manual_s) start_iter = 1'b1;
        else              state_n    = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // A finished command either stops the run, enters its gap, or (zero
    // wait) advances straight to the next request.
    if (cmd_done) begin
      if (lb_manual_s)                state_n = ST_IDLE;
      else if (I_wait_value == 8'd0)  step    = 1'b1;
      else begin
        gap_cnt_n = I_wait_value;
        state_n   = write_phase ? ST_WR_GAP : ST_RD_GAP;
      end
    end

    if (step) begin
      if (last_word) begin
        if (write_phase) begin
          addr_n  = start_q;
          lfsr_n  = pLFSR_SEED;
          state_n = ST_RD_REQ;
        end else begin
          state_n = ST_ITER_DONE;
        end
      end else begin
        addr_n  = addr + 32'd1;
        state_n = write_phase ? ST_WR_REQ : ST_RD_REQ;
      end
    end

    if (start_iter) begin
      start_n = I_start_addr;
      stop_n  = I_stop_addr;
      mode_n  = I_lfsr_mode;
      addr_n  = I_start_addr;
      lfsr_n  = pLFSR_SEED;
      state_n = ST_WR_REQ;
    end

    // Clear wins over a miscompare recorded in the same cycle.
    if (clear_fail_s) begin
      fail_n       = 1'b0;
      errors_n     = 32'd0;
      error_addr_n = 32'd0;
      iter_seen_n  = 1'b0;
    end

    pass_n = iter_seen_n && (errors_n == 32'd0);
  end

  always_ff @(posedge hclk or posedge reset_i) begin
    if (reset_i) begin
      state               <= ST_IDLE;
      addr                <= 32'd0;
      start_q             <= 32'd0;
      stop_q              <= 32'd0;
      mode_q              <= 1'b0;
      lfsr                <= pLFSR_SEED;
      gap_cnt             <= 8'd0;
      iter_seen           <= 1'b0;
      O_auto_pass         <= 1'b0;
      O_auto_fail         <= 1'b0;
      O_auto_iterations   <= 16'd0;
      O_auto_current_addr <= 32'd0;
      O_auto_errors       <= 32'd0;
      O_auto_error_addr   <= 32'd0;
    end else begin
      state               <= state_n;
      addr                <= addr_n;
      start_q             <= start_n;
      stop_q              <= stop_n;
      mode_q              <= mode_n;
      lfsr                <= lfsr_n;
      gap_cnt             <= gap_cnt_n;
      iter_seen           <= iter_seen_n;
      O_auto_pass         <= pass_n;
      O_auto_fail         <= fail_n;
      O_auto_iterations   <= iterations_n;
      O_auto_current_addr <= current_addr_n;
      O_auto_errors       <= errors_n;
      O_auto_error_addr   <= error_addr_n;
    end
  end

endmodule

// File: tb/tb_hyperram_auto_test.sv
// -----------------------------------------------------------------------------
// tb_hyperram_auto_test
//
// Directed bench for hyperram_auto_test. A negedge responder acts as an ideal
// word memory (optional single-word corruption, configurable read latency,
// optional random ready stalls), logs every accepted command, and watches
// gap length and request stability. The main initial block walks through the
// scenarios in order and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_hyperram_auto_test;

  logic        hclk = 1'b0;
  logic        reset_i;
  logic        I_lb_manual, I_clear_fail, I_lfsr_mode;
  logic [31:0] I_start_addr, I_stop_addr;
  logic [7:0]  I_wait_value;
  logic        O_cmd_valid, I_cmd_ready, O_cmd_write;
  logic [31:0] O_cmd_addr, O_cmd_wdata;
  logic        I_rd_valid;
  logic [31:0] I_rd_data;
  logic        O_auto_pass, O_auto_fail, O_busy;
  logic [15:0] O_auto_iterations;
  logic [31:0] O_auto_current_addr, O_auto_errors, O_auto_error_addr;

  always #5 hclk = ~hclk;

  hyperram_auto_test dut (
    .hclk                (hclk),
    .reset_i             (reset_i),
    .I_lb_manual         (I_lb_manual),
    .I_clear_fail        (I_clear_fail),
    .I_lfsr_mode         (I_lfsr_mode),
    .I_start_addr        (I_start_addr),
    .I_stop_addr         (I_stop_addr),
    .I_wait_value        (I_wait_value),
    .O_cmd_valid         (O_cmd_valid),
    .I_cmd_ready         (I_cmd_ready),
    .O_cmd_write         (O_cmd_write),
    .O_cmd_addr          (O_cmd_addr),
    .O_cmd_wdata         (O_cmd_wdata),
    .I_rd_valid          (I_rd_valid),
    .I_rd_data           (I_rd_data),
    .O_auto_pass         (O_auto_pass),
    .O_auto_fail         (O_auto_fail),
    .O_auto_iterations   (O_auto_iterations),
    .O_auto_current_addr (O_auto_current_addr),
    .O_auto_errors       (O_auto_errors),
    .O_auto_error_addr   (O_auto_error_addr),
    .O_busy              (O_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Responder / monitor state
  int          cyc = 0;
  logic [31:0] mem [0:255];
  logic [31:0] log_addr [0:63];
  logic [31:0] log_data [0:63];
  logic        log_wr   [0:63];
  int          log_n = 0;
  int          rd_lat = 2;
  int          rd_cnt = 0;
  logic [31:0] rd_addr_q = 32'd0;
  bit          ready_rand = 1'b0;
  int          dly = 0;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h12;
  bit          gap_en = 1'b0;
  bit          stab_en = 1'b0;
  int          stab_viol = 0;
  int          gap_n = 0;
  int          last_done = 0;
  int          valid_cnt = 0;
  logic        v_prev = 1'b0, w_prev = 1'b0;
  logic [31:0] a_prev = 32'd0, d_prev = 32'd0;

  // Hand-computed Galois sequence from seed 0xACE1_0001, taps 0x8020_0003.
  logic [31:0] lfsr_vec [0:3];
  initial begin
    lfsr_vec[0] = 32'hACE1_0001;
    lfsr_vec[1] = 32'hD650_8003;
    lfsr_vec[2] = 32'hEB08_4002;
    lfsr_vec[3] = 32'h7584_2001;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_iters(input logic [15:0] target, input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(negedge hclk);
      if (O_auto_iterations == target) break;
    end
    check(tag, 32'(O_auto_iterations), 32'(target));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(negedge hclk);
      if (!O_busy) break;
    end
    check(tag, 32'(O_busy), 32'd0);
  endtask

  task automatic pulse_clear();
    I_clear_fail = 1'b1;
    repeat (4) @(negedge hclk);
    I_clear_fail = 1'b0;
    repeat (4) @(negedge hclk);
  endtask

  // Memory / ready responder and monitors. Handshakes and read strobes are
  // inferred from values seen at the previous negedge, which were stable
  // across the intervening posedge.
  initial begin
    logic hs;
    forever begin
      @(negedge hclk);
      cyc++;
      hs = v_prev && I_cmd_ready;
      if (hs) begin
        if (log_n < 64) begin
          log_addr[log_n] = a_prev;
          log_data[log_n] = d_prev;
          log_wr[log_n]   = w_prev;
          log_n++;
        end
        if (w_prev) begin
          mem[a_prev[7:0]] = d_prev;
          last_done = cyc;
        end else begin
          rd_addr_q = a_prev;
          rd_cnt    = rd_lat;
        end
      end
      if (I_rd_valid) last_done = cyc;

      if (stab_en && v_prev && !I_cmd_ready &&
          (!O_cmd_valid || O_cmd_addr !== a_prev || O_cmd_write !== w_prev || O_cmd_wdata !== d_prev))
        stab_viol++;
      if (gap_en && O_cmd_valid && !v_prev && O_cmd_addr != 32'h10) begin
        gap_n++;
        check("gap_idle_cycles", 32'(cyc - last_done), 32'd5);
      end
      if (O_cmd_valid) valid_cnt++;

      I_rd_valid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          I_rd_valid = 1'b1;
          I_rd_data  = mem[rd_addr_q[7:0]] ^
                       ((corrupt_en && rd_addr_q == corrupt_addr) ? 32'h1 : 32'h0);
        end
      end

      if (!ready_rand) begin
        I_cmd_ready = 1'b1;
      end else begin
        if (hs) dly = $urandom_range(1, 3);
        if (O_cmd_valid) begin
          if (dly == 0) I_cmd_ready = 1'b1;
          else begin
            I_cmd_ready = 1'b0;
            dly--;
          end
        end else begin
          I_cmd_ready = 1'b0;
        end
      end

      v_prev = O_cmd_valid;
      w_prev = O_cmd_write;
      a_prev = O_cmd_addr;
      d_prev = O_cmd_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i      = 1'b1;
    I_lb_manual  = 1'b1;
    I_clear_fail = 1'b0;
    I_lfsr_mode  = 1'b0;
    I_start_addr = 32'd0;
    I_stop_addr  = 32'd0;
    I_wait_value = 8'd0;
    I_cmd_ready  = 1'b1;
    I_rd_valid   = 1'b0;
    I_rd_data    = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;

    // Reset state
    repeat (3) @(negedge hclk);
    check("rst_valid",   32'(O_cmd_valid), 32'd0);
    check("rst_write",   32'(O_cmd_write), 32'd0);
    check("rst_addr",    O_cmd_addr, 32'd0);
    check("rst_wdata",   O_cmd_wdata, 32'd0);
    check("rst_pass",    32'(O_auto_pass), 32'd0);
    check("rst_fail",    32'(O_auto_fail), 32'd0);
    check("rst_iters",   32'(O_auto_iterations), 32'd0);
    check("rst_cur",     O_auto_current_addr, 32'd0);
    check("rst_errors",  O_auto_errors, 32'd0);
    check("rst_erraddr", O_auto_error_addr, 32'd0);
    check("rst_busy",    32'(O_busy), 32'd0);
    reset_i = 1'b0;

    // Manual mode: no requests for 100 cycles
    valid_cnt = 0;
    repeat (100) @(negedge hclk);
    check("manual_no_valid", 32'(valid_cnt), 32'd0);
    check("manual_busy", 32'(O_busy), 32'd0);

    // Address data, window 0x10..0x13, zero wait, ready tied high
    I_start_addr = 32'h10;
    I_stop_addr  = 32'h13;
    log_n        = 0;
    I_lb_manual  = 1'b0;
    wait_iters(16'd1, 300, "a_iters");
    check("a_pass",   32'(O_auto_pass), 32'd1);
    check("a_fail",   32'(O_auto_fail), 32'd0);
    check("a_errors", O_auto_errors, 32'd0);
    check("a_cur",    O_auto_current_addr, 32'h13);
    I_lb_manual = 1'b1;
    wait_idle(100, "a_idle");
    check("a_iters_kept", 32'(O_auto_iterations), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("a_wr_flag", 32'(log_wr[i]), 32'd1);
      check("a_wr_addr", log_addr[i], 32'h10 + 32'(i));
      check("a_wr_data", log_data[i], 32'h10 + 32'(i));
    end
    check("a_rd_flag", 32'(log_wr[4]), 32'd0);
    check("a_rd_addr", log_addr[4], 32'h10);

    // LFSR data over the same window
    I_lfsr_mode = 1'b1;
    log_n       = 0;
    I_lb_manual = 1'b0;
    wait_iters(16'd2, 300, "b_iters");
    check("b_pass",   32'(O_auto_pass), 32'd1);
    check("b_errors", O_auto_errors, 32'd0);
    I_lb_manual = 1'b1;
    wait_idle(100, "b_idle");
    for (int i = 0; i < 4; i++) check("b_wr_data", log_data[i], lfsr_vec[i]);
    check("b_rd_flag", 32'(log_wr[4]), 32'd0);

    // Word 0x12 corrupted on every read, three iterations
    I_lfsr_mode  = 1'b0;
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h12;
    I_lb_manual  = 1'b0;
    wait_iters(16'd5, 600, "c_iters");
    check("c_errors",  O_auto_errors, 32'd3);
    check("c_erraddr", O_auto_error_addr, 32'h12);
    check("c_fail",    32'(O_auto_fail), 32'd1);
    check("c_pass",    32'(O_auto_pass), 32'd0);
    I_lb_manual = 1'b1;
    wait_idle(100, "c_idle");
    pulse_clear();
    check("clr_errors",  O_auto_errors, 32'd0);
    check("clr_fail",    32'(O_auto_fail), 32'd0);
    check("clr_erraddr", O_auto_error_addr, 32'd0);
    check("clr_pass",    32'(O_auto_pass), 32'd0);
    check("clr_iters",   32'(O_auto_iterations), 32'd5);
    corrupt_en  = 1'b0;
    I_lb_manual = 1'b0;
    wait_iters(16'd6, 300, "c2_iters");
    check("c2_pass", 32'(O_auto_pass), 32'd1);
    I_lb_manual = 1'b1;
    wait_idle(100, "c2_idle");

    // Five-cycle gaps with random ready stalls
    I_wait_value = 8'd5;
    ready_rand   = 1'b1;
    gap_n        = 0;
    stab_viol    = 0;
    gap_en       = 1'b1;
    stab_en      = 1'b1;
    I_lb_manual  = 1'b0;
    wait_iters(16'd7, 2000, "d_iters");
    check("d_pass", 32'(O_auto_pass), 32'd1);
    I_lb_manual = 1'b1;
    wait_idle(200, "d_idle");
    gap_en     = 1'b0;
    stab_en    = 1'b0;
    ready_rand = 1'b0;
    check("d_gap_count", 32'(gap_n), 32'd6);
    check("d_stable",    32'(stab_viol), 32'd0);
    I_wait_value = 8'd0;

    // Stop while a read is outstanding: the compare still happens
    rd_lat       = 20;
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h10;
    I_lb_manual  = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge hclk);
      if (rd_cnt != 0) break;
    end
    check("e_rd_pending", 32'(rd_cnt != 0), 32'd1);
    I_lb_manual = 1'b1;
    repeat (5) @(negedge hclk);
    check("e_busy_waiting", 32'(O_busy), 32'd1);
    wait_idle(100, "e_idle");
    check("e_iters",   32'(O_auto_iterations), 32'd7);
    check("e_errors",  O_auto_errors, 32'd1);
    check("e_erraddr", O_auto_error_addr, 32'h10);
    check("e_fail",    32'(O_auto_fail), 32'd1);
    check("e_pass",    32'(O_auto_pass), 32'd0);
    rd_lat     = 2;
    corrupt_en = 1'b0;
    pulse_clear();

    // Inverted window: single word at start_addr per phase
    I_start_addr = 32'h08;
    I_stop_addr  = 32'h05;
    log_n        = 0;
    I_lb_manual  = 1'b0;
    wait_iters(16'd8, 300, "f_iters");
    check("f_pass", 32'(O_auto_pass), 32'd1);
    check("f_cur",  O_auto_current_addr, 32'h08);
    I_lb_manual = 1'b1;
    wait_idle(100, "f_idle");
    check("f_wr_flag", 32'(log_wr[0]), 32'd1);
    check("f_wr_addr", log_addr[0], 32'h08);
    check("f_wr_data", log_data[0], 32'h08);
    check("f_rd_flag", 32'(log_wr[1]), 32'd0);
    check("f_rd_addr", log_addr[1], 32'h08);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
